key_debounce: RTL and testbench



---
 rtl/key_pkg.sv | 14 +
 rtl/key_debounce_ch.sv | 141 ++++++++++++++
 rtl/key_debounce.sv | 36 +++
 tb/tb_key_debounce.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and board-level timing constants for the push-button debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PRESS_DB = 2'b01,
        PRESSED  = 2'b10,
        REL_DB   = 2'b11
    } key_fsm_e;

    localparam int DEB_10MS_50MHZ = 500000;
    localparam int LONG_1S_50MHZ  = 50000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One button: 2-flop synchroniser, debounce FSM, registered level and strobes.
// Long-press detection is built only when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_10MS_50MHZ,
    parameter int ACTIVE_LOW  = 1,
    parameter int LONG_CYCLES = LONG_1S_50MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic             IDLE_LVL = (ACTIVE_LOW != 0);

    if (DEB_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_param
        $error("key_debounce_ch: DEB_CYCLES must be >= 2 and LONG_CYCLES >= 1");
    end

    logic             sync_p0;
    logic             sync_p1;
    logic             pressed;
    key_fsm_e         state;
    key_fsm_e         state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             key_state_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // XOR with the idle pin level normalises to pressed = 1 for either polarity.
    assign pressed = sync_p1 ^ IDLE_LVL;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0       <= IDLE_LVL;
            sync_p1       <= IDLE_LVL;
            state         <= IDLE;
            cnt           <= '0;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_p0       <= key_raw;
            sync_p1       <= sync_p0;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            key_state     <= key_state_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        key_state_nxt = key_state;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (!pressed) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt     = PRESSED;
                    cnt_nxt       = '0;
                    key_state_nxt = 1'b1;
                    press_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_nxt = REL_DB;
                    cnt_nxt   = '0;
                end
            end
            REL_DB: begin
                // A bounce back to pressed is absorbed silently; key_state never dropped.
                if (pressed) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt     = IDLE;
                    cnt_nxt       = '0;
                    key_state_nxt = 1'b0;
                    release_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int                HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_cnt;

    // Cleared only on a debounced press, so REL_DB bounces keep the running count.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (press_nxt) begin
                hold_cnt <= '0;
            end else if ((state == PRESSED || state == REL_DB) && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_MAX - 1'b1) begin
                    long_pulse <= 1'b1;
                end
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// NKEYS independent debounced push-buttons with press/release (and optional long-press) strobes.
// Optional feature macro: KEY_DEBOUNCE_LONG_PRESS_EN (long_pulse is constant 0 without it).
module key_debounce
    import key_pkg::*;
#(
    parameter int NKEYS       = 3,
    parameter int DEB_CYCLES  = DEB_10MS_50MHZ,
    parameter int ACTIVE_LOW  = 1,
    parameter int LONG_CYCLES = LONG_1S_50MHZ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_raw,
    output logic [NKEYS-1:0] key_state,
    output logic [NKEYS-1:0] press_pulse,
    output logic [NKEYS-1:0] release_pulse,
    output logic [NKEYS-1:0] long_pulse
);

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        key_debounce_ch #(
            .DEB_CYCLES  (DEB_CYCLES),
            .ACTIVE_LOW  (ACTIVE_LOW),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .key_raw       (key_raw[k]),
            .key_state     (key_state[k]),
            .press_pulse   (press_pulse[k]),
            .release_pulse (release_pulse[k]),
            .long_pulse    (long_pulse[k])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: expected strobes are queued when a pin is driven
// and compared every cycle against all pulse outputs.
module tb_key_debounce;

    localparam int NK   = 3;
    localparam int DEB  = 4;
    localparam int LONG = 10;
    localparam int LAT  = DEB + 3;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    typedef struct {
        int at;
        int key;
        int kind;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_state;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] long_pulse;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  t0;
    int  t1;
    ev_t sb[$];

    key_debounce #(
        .NKEYS       (NK),
        .DEB_CYCLES  (DEB),
        .ACTIVE_LOW  (1),
        .LONG_CYCLES (LONG)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_raw       (key_raw),
        .key_state     (key_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle: all strobes must match exactly the events scheduled for this cycle.
    always @(negedge clk) begin
        logic [3*NK-1:0] exp_v;
        logic [3*NK-1:0] obs_v;
        exp_v = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                exp_v[sb[i].kind * NK + sb[i].key] = 1'b1;
                sb.delete(i);
            end
        end
        obs_v = {long_pulse, release_pulse, press_pulse};
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL pulses cyc=%0d observed(long,rel,press)=%b expected=%b", cyc, obs_v, exp_v);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int at, input int key, input int kind);
        sb.push_back('{at, key, kind});
    endtask

    task automatic check_state(input string tag, input logic [NK-1:0] exp);
        checks++;
        assert (key_state === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed key_state=%b expected=%b", tag, cyc, key_state, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        key_raw = '1;
        step(3);
        check_state("reset_hold", 3'b000);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_state("idle_after_reset", 3'b000);
        end

        // Clean press and release on key 0.
        key_raw[0] = 1'b0;
        t0 = cyc;
        push(t0 + LAT, 0, K_PRESS);
        step(LAT - 1);
        check_state("k0_before_press", 3'b000);
        step(1);
        check_state("k0_pressed", 3'b001);
        step(1);
        key_raw[0] = 1'b1;
        t1 = cyc;
        push(t1 + LAT, 0, K_RELEASE);
        step(LAT - 1);
        check_state("k0_before_release", 3'b001);
        step(1);
        check_state("k0_released", 3'b000);
        step(5);

        // Bouncing key 1: never stable long enough.
        for (int i = 0; i < 8; i++) begin
            key_raw[1] = i[0];
            step(2);
            check_state("k1_bounce", 3'b000);
        end
        step(10);
        check_state("k1_after_bounce", 3'b000);

        // Key 2 pressed, short release glitch absorbed.
        key_raw[2] = 1'b0;
        t0 = cyc;
        push(t0 + LAT, 2, K_PRESS);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        push(t0 + LAT + LONG, 2, K_LONG);
`endif
        step(LAT);
        check_state("k2_pressed", 3'b100);
        step(3);
        key_raw[2] = 1'b1;
        step(2);
        key_raw[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check_state("k2_glitch", 3'b100);
        end
        step(5);
        key_raw[2] = 1'b1;
        t1 = cyc;
        push(t1 + LAT, 2, K_RELEASE);
        step(LAT);
        check_state("k2_released", 3'b000);
        step(5);

        // Reset while key 0 is held: silent drop, then fresh press after full latency.
        key_raw[0] = 1'b0;
        t0 = cyc;
        push(t0 + LAT, 0, K_PRESS);
        step(LAT + 3);
        check_state("k0_held", 3'b001);
        reset = 1'b1;
        step(1);
        check_state("k0_reset", 3'b000);
        reset = 1'b0;
        t1 = cyc;
        push(t1 + LAT, 0, K_PRESS);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        push(t1 + LAT + LONG, 0, K_LONG);
`endif
        step(LAT - 1);
        check_state("k0_repress_wait", 3'b000);
        step(1);
        check_state("k0_repressed", 3'b001);
        step(23);
        check_state("k0_long_hold", 3'b001);
        key_raw[0] = 1'b1;
        t0 = cyc;
        push(t0 + LAT, 0, K_RELEASE);
        step(LAT);
        check_state("k0_final_release", 3'b000);
        step(10);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drained observed=%0d pending expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
